// File: rtl/snapshot_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snapshot_pkg
//  Description : Shared types and bit-index constants for the snapshot
//                capture controller (FSM state encoding, ctrl word fields,
//                status word fields).
//  Revision    : 1.0 - initial release
// ============================================================================
package snapshot_pkg;

    // Capture sequencer states
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_DELAY   = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    // Software control word bit positions
    localparam int CTRL_ARM      = 0;   // rising edge arms the capture
    localparam int CTRL_TRIG_IMM = 1;   // 1 = trigger immediately once armed
    localparam int CTRL_WE_ALL   = 2;   // 1 = every cycle carries a valid sample
    localparam int CTRL_CIRC     = 3;   // 1 = circular capture until stop

    // Status word bit positions
    localparam int ST_DONE = 31;
    localparam int ST_WRAP = 30;
    localparam int ST_BUSY = 29;

endpackage : snapshot_pkg
`default_nettype wire

// File: rtl/snapshot_capture_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : snapshot_capture_ctrl_if
//  Description : Datapath-facing bundle of the snapshot capture controller:
//                the incoming sample stream (din/we/trig/stop) and the
//                outgoing BRAM write port (bram_addr/bram_data/bram_we).
//  Modports    : master - sample source / BRAM sink side
//                slave  - the capture controller
//  Revision    : 1.0 - initial release
// ============================================================================
interface snapshot_capture_ctrl_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 10
);
    logic [DATA_WIDTH-1:0] din;
    logic                  we;
    logic                  trig;
    logic                  stop;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [DATA_WIDTH-1:0] bram_data;
    logic                  bram_we;

    modport master (
        output din, we, trig, stop,
        input  bram_addr, bram_data, bram_we
    );

    modport slave (
        input  din, we, trig, stop,
        output bram_addr, bram_data, bram_we
    );
endinterface : snapshot_capture_ctrl_if
`default_nettype wire

// File: rtl/snapshot_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : snapshot_addr_gen
//  Description : BRAM write address counter for the snapshot capture.
//                Keeps one extra count bit so a full one-shot buffer reads
//                2**ADDR_WIDTH; in circular mode the counter wraps to 0 at
//                the last address and raises a sticky wrapped flag.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                i_clear       - restart at address 0, clear wrapped
//                i_inc         - one sample written at o_addr
//                i_circ        - circular mode (wrap instead of counting on)
//                o_addr        - current write address
//                o_count       - ADDR_WIDTH+1 bit sample count / next address
//                o_wrapped     - circular buffer has wrapped at least once
//                o_last        - terminal count: o_addr is the last address
//  Revision    : 1.0 - initial release
// ============================================================================
module snapshot_addr_gen #(
    parameter int ADDR_WIDTH = 10
) (
    input  wire                  clk,
    input  wire                  rst,
    input  wire                  i_clear,
    input  wire                  i_inc,
    input  wire                  i_circ,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_wrapped,
    output logic                  o_last
);

    logic [ADDR_WIDTH:0] r_cnt;
    logic                r_wrapped;

    assign o_addr    = r_cnt[ADDR_WIDTH-1:0];
    assign o_count   = r_cnt;
    assign o_wrapped = r_wrapped;
    assign o_last    = &r_cnt[ADDR_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt     <= '0;
            r_wrapped <= 1'b0;
        end else if (i_inc) begin
            if (o_last && i_circ) begin
                r_cnt     <= '0;
                r_wrapped <= 1'b1;
            end else begin
                // One-shot: the final write rolls the MSB so count = depth
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule : snapshot_addr_gen
`default_nettype wire

// File: rtl/snapshot_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : snapshot_capture_ctrl
//  Description : Sequences one snapshot capture into the snapshot BRAM.
//                Supports one-shot / circular capture, immediate / external
//                trigger and a post-trigger discard offset. Write port and
//                status word are registered (1 cycle after the event).
//  Ports       : user_clk     - sole clock
//                user_rst     - synchronous active-high reset
//                ctrl         - software control word (arm/trig_src/we_src/circ)
//                trig_offset  - qualified samples discarded after trigger
//                status       - {done, wrapped, busy, ..., count}
//                bus          - sample stream in, BRAM write port out
//  Revision    : 1.0 - initial release
// ============================================================================
module snapshot_capture_ctrl
    import snapshot_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 10,
    parameter int OFFSET_WIDTH = 16
) (
    input  wire                     user_clk,
    input  wire                     user_rst,
    input  wire [31:0]              ctrl,
    input  wire [OFFSET_WIDTH-1:0]  trig_offset,
    output logic [31:0]             status,
    snapshot_capture_ctrl_if.slave  bus
);

    // ------------------------------------------------------------------
    // Qualified strobes and arm edge detection
    // ------------------------------------------------------------------
    logic w_qv;
    logic w_qt;
    logic w_arm_edge;
    logic r_arm_d;
    logic w_unused_ctrl;

    assign w_qv          = bus.we   | ctrl[CTRL_WE_ALL];
    assign w_qt          = bus.trig | ctrl[CTRL_TRIG_IMM];
    assign w_arm_edge    = ctrl[CTRL_ARM] & ~r_arm_d;
    assign w_unused_ctrl = ^ctrl[31:4];

    // ------------------------------------------------------------------
    // State and working registers
    // ------------------------------------------------------------------
    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [OFFSET_WIDTH-1:0] r_offset;
    logic [OFFSET_WIDTH-1:0] w_offset_nxt;
    logic                    r_circ;
    logic                    w_circ_nxt;
    logic                    w_write;
    logic                    w_circ_eff;

    logic                    r_done;
    logic                    r_busy;
    logic                    r_bram_we;
    logic [ADDR_WIDTH-1:0]   r_bram_addr;
    logic [DATA_WIDTH-1:0]   r_bram_data;

    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [ADDR_WIDTH:0]     w_count;
    logic                    w_wrapped;
    logic                    w_last;

    // The circ bit is captured at the trigger; in the trigger cycle itself
    // the live value is the one that applies.
    assign w_circ_eff = (r_state == S_ARMED) ? ctrl[CTRL_CIRC] : r_circ;

    // ------------------------------------------------------------------
    // Address generator
    // ------------------------------------------------------------------
    snapshot_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk       (user_clk),
        .rst       (user_rst),
        .i_clear   (w_arm_edge),
        .i_inc     (w_write),
        .i_circ    (w_circ_eff),
        .o_addr    (w_addr),
        .o_count   (w_count),
        .o_wrapped (w_wrapped),
        .o_last    (w_last)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and sample acceptance
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_offset_nxt = r_offset;
        w_circ_nxt   = r_circ;
        w_write      = 1'b0;

        if (w_arm_edge) begin
            // Re-arm wins over everything, including a running capture
            w_state_nxt  = S_ARMED;
            w_offset_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                end

                S_ARMED: begin
                    if (w_qt) begin
                        w_circ_nxt = ctrl[CTRL_CIRC];
                        if (trig_offset == '0) begin
                            w_state_nxt = S_CAPTURE;
                            w_write     = w_qv;
                        end else if (w_qv) begin
                            // The trigger-cycle sample is the first post-
                            // trigger sample, so it is the first discard.
                            if (trig_offset == OFFSET_WIDTH'(1)) begin
                                w_state_nxt  = S_CAPTURE;
                                w_offset_nxt = '0;
                            end else begin
                                w_state_nxt  = S_DELAY;
                                w_offset_nxt = trig_offset - OFFSET_WIDTH'(1);
                            end
                        end else begin
                            w_state_nxt  = S_DELAY;
                            w_offset_nxt = trig_offset;
                        end
                    end
                end

                S_DELAY: begin
                    if (w_qv) begin
                        if (r_offset == OFFSET_WIDTH'(1)) begin
                            w_state_nxt  = S_CAPTURE;
                            w_offset_nxt = '0;
                        end else begin
                            w_offset_nxt = r_offset - OFFSET_WIDTH'(1);
                        end
                    end
                end

                S_CAPTURE: begin
                    w_write = w_qv;
                    if (r_circ) begin
                        // A sample arriving with stop is still written
                        if (bus.stop) begin
                            w_state_nxt = S_DONE;
                        end
                    end else if (w_qv && w_last) begin
                        w_state_nxt = S_DONE;
                    end
                end

                S_DONE: begin
                end

                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Working registers, write port and status flags
    // ------------------------------------------------------------------
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r_arm_d     <= 1'b1;   // a level already high at reset does not arm
            r_offset    <= '0;
            r_circ      <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_bram_we   <= 1'b0;
            r_bram_addr <= '0;
            r_bram_data <= '0;
        end else begin
            r_arm_d   <= ctrl[CTRL_ARM];
            r_offset  <= w_offset_nxt;
            r_circ    <= w_circ_nxt;
            r_done    <= (w_state_nxt == S_DONE);
            r_busy    <= (w_state_nxt == S_ARMED) ||
                         (w_state_nxt == S_DELAY) ||
                         (w_state_nxt == S_CAPTURE);
            r_bram_we <= w_write;
            if (w_write) begin
                r_bram_addr <= w_addr;
                r_bram_data <= bus.din;
            end
        end
    end

    assign bus.bram_we   = r_bram_we;
    assign bus.bram_addr = r_bram_addr;
    assign bus.bram_data = r_bram_data;

    // All status sources are flops updated on the same edge as the write port
    always_comb begin
        status               = '0;
        status[ST_DONE]      = r_done;
        status[ST_WRAP]      = w_wrapped;
        status[ST_BUSY]      = r_busy;
        status[ADDR_WIDTH:0] = w_count;
    end

endmodule : snapshot_capture_ctrl
`default_nettype wire
